// File: rtl/pal_cfg_loader.sv
// -----------------------------------------------------------------------------
// pal_cfg_loader
//   Serial configuration controller for the PAL crosspoint array. Crosspoint
//   enables arrive one bit per accepted valid/ready beat, are collected in a
//   shadow register and are copied to the active register in a single commit
//   cycle. The PAL keeps its previous configuration during a load.
//
// Ports
//   clk         in   1         single clock, all state on the rising edge
//   rst         in   1         synchronous reset, active-high
//   cfg_start   in   1         pulse: begin (or restart) a load
//   cfg_data    in   1         serial configuration bit
//   cfg_valid   in   1         cfg_data is valid this cycle
//   cfg_ready   out  1         a bit is accepted this cycle (state LOAD)
//   cfg_busy    out  1         loader is not idle
//   cfg_done    out  1         pulse: new config visible on and_cfg/or_cfg
//   cfg_loaded  out  1         sticky: at least one commit since reset
//   and_cfg     out  AND_BITS  active AND-plane crosspoint enables
//   or_cfg      out  OR_BITS   active OR-plane crosspoint enables
// -----------------------------------------------------------------------------
module pal_cfg_loader #(
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_PTERMS  = 16,
    parameter int NUM_OUTPUTS = 4,
    localparam int AND_BITS   = 2 * NUM_INPUTS * NUM_PTERMS,
    localparam int OR_BITS    = NUM_PTERMS * NUM_OUTPUTS,
    localparam int CFG_BITS   = AND_BITS + OR_BITS,
    localparam int CNT_W      = $clog2(CFG_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_loaded,
    output logic [AND_BITS-1:0] and_cfg,
    output logic [OR_BITS-1:0]  or_cfg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    count_r;
    logic [CFG_BITS-1:0] shadow_r;
    logic [CFG_BITS-1:0] active_r;
    logic                ready_r;
    logic                busy_r;
    logic                done_r;
    logic                loaded_r;
    logic                ready_nxt_s;
    logic                busy_nxt_s;
    logic                done_nxt_s;
    logic                loaded_nxt_s;
    logic                accept_s;
    logic                last_bit_s;

    // A restart pulse takes priority over a data beat in the same cycle.
    assign accept_s   = (state_r == ST_LOAD) && cfg_valid && !cfg_start;
    assign last_bit_s = (count_r == CNT_W'(CFG_BITS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: cfg_start is only honoured from IDLE or LOAD.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s && last_bit_s) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_COMMIT: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: values the status registers take on the next edge.
    always_comb begin
        ready_nxt_s  = 1'b0;
        busy_nxt_s   = 1'b0;
        done_nxt_s   = 1'b0;
        loaded_nxt_s = loaded_r;
        if (state_nxt_s == ST_LOAD) begin
            ready_nxt_s = 1'b1;
        end else begin
            ready_nxt_s = 1'b0;
        end
        if (state_nxt_s != ST_IDLE) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
        // done and loaded rise together with the active-register update.
        if (state_r == ST_COMMIT) begin
            done_nxt_s   = 1'b1;
            loaded_nxt_s = 1'b1;
        end else begin
            done_nxt_s   = 1'b0;
            loaded_nxt_s = loaded_r;
        end
    end

    // Status output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            loaded_r <= 1'b0;
        end else begin
            ready_r  <= ready_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            loaded_r <= loaded_nxt_s;
        end
    end

    // Bit counter and shadow shift register. The shadow is never cleared on
    // restart: a complete load overwrites every stale bit anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= {CNT_W{1'b0}};
            shadow_r <= {CFG_BITS{1'b0}};
        end else if ((state_r == ST_LOAD) && cfg_start) begin
            count_r  <= {CNT_W{1'b0}};
            shadow_r <= shadow_r;
        end else if (accept_s) begin
            shadow_r <= {shadow_r[CFG_BITS-2:0], cfg_data};
            if (last_bit_s) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (state_r != ST_LOAD) begin
            count_r  <= {CNT_W{1'b0}};
            shadow_r <= shadow_r;
        end else begin
            count_r  <= count_r;
            shadow_r <= shadow_r;
        end
    end

    // Active register: updated only in the commit cycle so the array never
    // sees a partially shifted configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r <= {CFG_BITS{1'b0}};
        end else if (state_r == ST_COMMIT) begin
            active_r <= shadow_r;
        end else begin
            active_r <= active_r;
        end
    end

    assign cfg_ready  = ready_r;
    assign cfg_busy   = busy_r;
    assign cfg_done   = done_r;
    assign cfg_loaded = loaded_r;
    // First bit shifted in lands in the AND-plane MSB, last bit in or_cfg[0].
    assign and_cfg    = active_r[CFG_BITS-1:OR_BITS];
    assign or_cfg     = active_r[OR_BITS-1:0];

endmodule

// File: tb/tb_pal_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_pal_cfg_loader
//   Directed self-checking bench for pal_cfg_loader with a 2-input, 2-term,
//   1-output PAL (10 configuration bits: 8 AND-plane + 2 OR-plane).
// -----------------------------------------------------------------------------
module tb_pal_cfg_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start;
    logic       cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_loaded;
    logic [7:0] and_cfg;
    logic [1:0] or_cfg;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int done_cnt = 0;
    int commits  = 0;

    pal_cfg_loader #(
        .NUM_INPUTS (2),
        .NUM_PTERMS (2),
        .NUM_OUTPUTS(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_loaded(cfg_loaded),
        .and_cfg   (and_cfg),
        .or_cfg    (or_cfg)
    );

    always #5 clk = ~clk;

    // Count every cfg_done cycle seen by the clock.
    always @(posedge clk) begin
        if (cfg_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("ready_after_start", {31'd0, cfg_ready}, 32'd1);
        check("busy_after_start", {31'd0, cfg_busy}, 32'd1);
    endtask

    // Send the first n bits of pat (MSB first); outputs must hold 'hold' throughout.
    task automatic send_bits(input logic [9:0] pat, input int n, input bit stall,
                             input logic [9:0] hold);
        int i = 0;
        int guard = 0;
        logic v;
        while (i < n && guard < 400) begin
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_valid = v;
            cfg_data  = pat[9-i];
            tick();
            if (v) i = i + 1;
            guard = guard + 1;
            check("hold_during_load", {22'd0, and_cfg, or_cfg}, {22'd0, hold});
            check("no_done_during_load", {31'd0, cfg_done}, 32'd0);
        end
        check("send_timeout", guard < 400 ? 32'd0 : 32'd1, 32'd0);
        cfg_valid = 1'b0;
    endtask

    // The cycle after the last accept is COMMIT; the new config appears one edge later.
    task automatic finish_commit(input logic [9:0] pat, input bit start_in_commit);
        cfg_start = start_in_commit;
        tick();
        cfg_start = 1'b0;
        commits = commits + 1;
        check("done_pulse", {31'd0, cfg_done}, 32'd1);
        check("and_cfg_commit", {24'd0, and_cfg}, {24'd0, pat[9:2]});
        check("or_cfg_commit", {30'd0, or_cfg}, {30'd0, pat[1:0]});
        check("busy_at_done", {31'd0, cfg_busy}, 32'd0);
        check("loaded_at_done", {31'd0, cfg_loaded}, 32'd1);
        tick();
        check("done_one_cycle", {31'd0, cfg_done}, 32'd0);
        check("idle_after_done", {30'd0, cfg_busy, cfg_ready}, 32'd0);
        check("done_per_commit", done_cnt, commits);
    endtask

    initial begin
        logic [9:0] cfg_a;
        logic [9:0] cfg_b;
        logic [9:0] cfg_c;
        cfg_a = 10'b10_1001_1011;   // and_cfg 8'hA6, or_cfg 2'b11
        cfg_b = 10'b01_0110_0100;   // and_cfg 8'h59, or_cfg 2'b00
        cfg_c = 10'b11_0000_1110;   // and_cfg 8'hC3, or_cfg 2'b10

        rst = 1'b1; cfg_start = 1'b0; cfg_data = 1'b0; cfg_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("reset_and_cfg", {24'd0, and_cfg}, 32'd0);
        check("reset_or_cfg", {30'd0, or_cfg}, 32'd0);
        check("reset_ready", {31'd0, cfg_ready}, 32'd0);
        check("reset_loaded", {31'd0, cfg_loaded}, 32'd0);
        check("reset_busy_done", {30'd0, cfg_busy, cfg_done}, 32'd0);

        // Full load with valid held high.
        start_load();
        send_bits(cfg_a, 10, 1'b0, 10'd0);
        finish_commit(cfg_a, 1'b0);

        // Stalled stream of a different config.
        start_load();
        send_bits(cfg_b, 10, 1'b1, cfg_a);
        finish_commit(cfg_b, 1'b0);

        // Restart mid-load: 5 ones, restart pulse (with a valid beat that must
        // be dropped), then config C; outputs go B -> C directly.
        start_load();
        send_bits(10'h3FF, 5, 1'b0, cfg_b);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 1'b1;
        tick();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        check("ready_after_restart", {31'd0, cfg_ready}, 32'd1);
        check("hold_at_restart", {22'd0, and_cfg, or_cfg}, {22'd0, cfg_b});
        send_bits(cfg_c, 10, 1'b0, cfg_b);
        finish_commit(cfg_c, 1'b0);

        // Ignored inputs: valid beats in IDLE, cfg_start in the COMMIT cycle.
        cfg_valid = 1'b1; cfg_data = 1'b1;
        repeat (3) tick();
        cfg_valid = 1'b0;
        check("idle_valid_ignored", {30'd0, cfg_busy, cfg_ready}, 32'd0);
        check("idle_hold", {22'd0, and_cfg, or_cfg}, {22'd0, cfg_c});
        start_load();
        send_bits(cfg_a, 10, 1'b0, cfg_c);
        finish_commit(cfg_a, 1'b1);
        repeat (3) tick();
        check("no_second_load", {30'd0, cfg_busy, cfg_ready}, 32'd0);

        // Hold during a partial load, then reset with nonzero outputs.
        start_load();
        send_bits(cfg_b, 9, 1'b0, cfg_a);
        repeat (4) tick();
        check("partial_hold", {22'd0, and_cfg, or_cfg}, {22'd0, cfg_a});
        check("partial_busy", {31'd0, cfg_busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_and_cfg", {24'd0, and_cfg}, 32'd0);
        check("rst_or_cfg", {30'd0, or_cfg}, 32'd0);
        check("rst_status", {28'd0, cfg_ready, cfg_busy, cfg_done, cfg_loaded}, 32'd0);
        // The discarded load must not complete: one more bit would have ended it.
        cfg_valid = 1'b1; cfg_data = 1'b0;
        repeat (4) tick();
        cfg_valid = 1'b0;
        check("rst_discards_load", {22'd0, and_cfg, or_cfg}, 32'd0);
        check("rst_idle", {29'd0, cfg_busy, cfg_done, cfg_loaded}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
